fetch_stage: RTL
================

# fetch_stage

Instruction-fetch front end that consumes the hazard unit's fetch/decode controls (stall_F, stall_D, flush_D, pcSource_E) and drives the IF/ID boundary. It owns the PC, issues in-order requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words in a small FIFO, and discards responses made stale by a taken branch or jump. Output is the decode-stage register set (instr_D, pc_D, pc4_D, valid_D).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BUF_DEPTH, 2, instruction FIFO depth; also the cap on outstanding plus buffered requests (≥2)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall_F  in  1  freeze PC and suppress new requests
- stall_D  in  1  hold the decode register
- flush_D  in  1  squash the decode register (insert bubble)
- pcSource_E  in  1  taken branch/jump resolved in execute
- target_E  in  32  redirect target, valid with pcSource_E
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address (= PC)
- imem_gnt  in  1  request accepted this cycle (PC advances)
- imem_rvalid  in  1  response valid, strictly in request order
- imem_rdata  in  32  response instruction
- instr_D  out  32  decode instruction (NOP 32'h0000_0013 when invalid)
- pc_D  out  32  PC of instr_D
- pc4_D  out  32  pc_D + 4
- valid_D  out  1  instr_D holds a real instruction

## Operation
- State: pc, outstanding (0..BUF_DEPTH), stale (0..BUF_DEPTH), FIFO {instr, pc} with count, decode register.
- Priority per cycle: reset > redirect (pcSource_E) > flush_D > stall_D / stall_F.
- Issue: imem_req = !stall_F && !pcSource_E && (outstanding + count − pop) < BUF_DEPTH, where pop = FIFO dequeued this cycle. imem_addr = pc.
- On imem_req && imem_gnt: pc <= pc + 4 (mod 2^32, wraps), outstanding +1.
- On imem_rvalid: outstanding −1. If stale > 0: stale −1, data dropped. Else push {imem_rdata, pc of the matching request} (the FIFO also tracks the request PC).
- Redirect (pcSource_E=1): pc <= target_E; FIFO cleared; stale <= outstanding after this cycle's grant/response updates; decode register loaded with bubble; no request this cycle.
- Decode register: flush_D or redirect → valid_D=0, instr_D=NOP, pc_D unchanged. Else if !stall_D: load FIFO head (valid_D=1) if count>0, else bubble. stall_D holds all decode outputs.
- Simultaneous grant and response handled in one cycle (outstanding unchanged); simultaneous push and pop handled when FIFO is full.
- target_E[1:0] ignored; imem_addr[1:0] is always 0.
- The FIFO never overflows; a push into a full FIFO is a design error (assertion).

## Timing
- Reset (async assert): pc=RESET_PC, outstanding=0, stale=0, count=0, valid_D=0, instr_D=NOP, pc_D=0, pc4_D=4; imem_req=0 while reset is high.
- First request in the first cycle after reset is released.
- Memory with a single-cycle response (gnt in cycle t, rvalid in t+1): the word is in the FIFO at the t+1 edge, and valid_D=1 in cycle t+3 (t+2 with bypass).
- Steady-state throughput is one instruction per cycle with BUF_DEPTH≥2, single-cycle memory, and no stalls.
- A redirect in cycle t makes the request for target_E in cycle t+1.
- Stall release: the held instruction advances on the first edge where stall_D=0.

## Configuration
- FETCH_BYPASS_EN defined: if FIFO count=0, the response is not stale, and the decode register is loading (not stalled, flushed, or redirected), imem_rdata goes straight into the decode register with no FIFO push. Fetch-to-decode latency drops by one cycle.
- Undefined: every response passes through the FIFO.

## Test plan
- Reset release, RESET_PC=0, single-cycle memory with instr=addr: valid_D rises in cycle 3 (cycle 2 with bypass); pc_D runs 0,4,8,… one per cycle.
- stall_F and stall_D held for 3 cycles mid-stream: instr_D/pc_D frozen, no requests, no FIFO overflow; the sequence resumes with no skipped or duplicated PC.
- Redirect to 0x100 while 2 requests are outstanding, 3-cycle memory latency: both responses dropped; the next valid_D shows pc_D=0x100.
- flush_D pulse alone: one bubble (valid_D=0, instr_D=0x13); the following instruction is not lost.
- imem_gnt withheld 5 cycles: imem_req stays high, imem_addr stays constant, pc does not advance.
- PC wrap: RESET_PC=0xFFFF_FFFC: second fetch address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order imem requests, buffers responses in a small FIFO
// and drives the IF/ID register. Define FETCH_BYPASS_EN to let responses skip an empty FIFO.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        pcSource_E,
  input  logic [31:0] target_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D
);

  localparam logic [31:0]      NOP       = 32'h0000_0013;
  localparam int               PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int               CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int               OCC_W     = CNT_W + 1;
  localparam logic [31:0]      PC_INIT   = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Fetch-side state
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] stale_q, stale_d;

  // Instruction FIFO
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fifo_instr_q [BUF_DEPTH];
  logic [31:0]      fifo_instr_d [BUF_DEPTH];
  logic [31:0]      fifo_pc_q    [BUF_DEPTH];
  logic [31:0]      fifo_pc_d    [BUF_DEPTH];

  // Decode register
  logic [31:0]      instr_D_q, instr_D_d;
  logic [31:0]      pc_D_q, pc_D_d;
  logic             valid_D_q, valid_D_d;

  logic             dec_load, pop, push, bypass, resp_fresh, req, grant;
  logic [OCC_W-1:0] occ;

  // Handshake and issue control
  always_comb begin
    dec_load   = !pcSource_E && !flush_D && !stall_D;
    pop        = dec_load && (cnt_q != '0);
    resp_fresh = imem_rvalid && (stale_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass     = dec_load && (cnt_q == '0) && resp_fresh;
`else
    bypass     = 1'b0;
`endif
    push       = resp_fresh && !pcSource_E && !bypass;
    // Occupancy counts words already in flight plus words buffered, net of this cycle's pop.
    occ        = {1'b0, out_q} + {1'b0, cnt_q} - OCC_W'(pop);
    req        = !reset && !stall_F && !pcSource_E && (occ < DEPTH_OCC);
    grant      = req && imem_gnt;
  end

  always_comb begin
    out_d = out_q + CNT_W'(grant) - CNT_W'(imem_rvalid);

    stale_d = stale_q;
    if (pcSource_E)
      stale_d = out_d;
    else if (imem_rvalid && (stale_q != '0))
      stale_d = stale_q - CNT_W'(1);

    pc_d = pc_q;
    if (pcSource_E)
      pc_d = word_align(target_E);
    else if (grant)
      pc_d = pc_q + 32'd4;

    // Fresh responses arrive in PC order from the last redirect, so one running PC suffices.
    resp_pc_d = resp_pc_q;
    if (pcSource_E)
      resp_pc_d = word_align(target_E);
    else if (resp_fresh)
      resp_pc_d = resp_pc_q + 32'd4;
  end

  always_comb begin
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    if (pcSource_E) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        fifo_instr_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]    = resp_pc_q;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
      end
      if (pop)
        rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    instr_D_d = instr_D_q;
    pc_D_d    = pc_D_q;
    valid_D_d = valid_D_q;
    if (pcSource_E || flush_D) begin
      instr_D_d = NOP;
      valid_D_d = 1'b0;
    end else if (!stall_D) begin
      if (cnt_q != '0) begin
        instr_D_d = fifo_instr_q[rd_ptr_q];
        pc_D_d    = fifo_pc_q[rd_ptr_q];
        valid_D_d = 1'b1;
      end else if (bypass) begin
        instr_D_d = imem_rdata;
        pc_D_d    = resp_pc_q;
        valid_D_d = 1'b1;
      end else begin
        instr_D_d = NOP;
        valid_D_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_INIT;
      resp_pc_q <= PC_INIT;
      out_q     <= '0;
      stale_q   <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      instr_D_q <= NOP;
      pc_D_q    <= '0;
      valid_D_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      stale_q   <= stale_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      instr_D_q <= instr_D_d;
      pc_D_q    <= pc_D_d;
      valid_D_q <= valid_D_d;
    end
  end

  // FIFO storage is qualified by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    fifo_instr_q <= fifo_instr_d;
    fifo_pc_q    <= fifo_pc_d;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (cnt_q == DEPTH_CNT) && !pop));

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign instr_D   = instr_D_q;
  assign pc_D      = pc_D_q;
  assign pc4_D     = pc_D_q + 32'd4;
  assign valid_D   = valid_D_q;

endmodule
